elbeth_lsu: RTL

Load/store unit that acts as the initiator on one port of the ELBETH dual-port memory. It accepts byte, halfword and word load/store requests from the pipeline and converts byte addresses to word addresses and byte strobes. It drives the memory enable/rw handshake, then aligns and sign- or zero-extends read data. Misaligned or illegal-size requests are rejected with an error response and no memory access.

---
 rtl/elbeth_lsu_if.sv | 43 ++++
 rtl/elbeth_lsu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/elbeth_lsu_if.sv
//----------------------------------------------------------------------------
// elbeth_lsu_if -- request/response and memory-port bundle for elbeth_lsu (rev 1.0)
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface elbeth_lsu_if #(
  parameter int AW = 12
);
  logic          req_valid;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_enable;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data_in;
  logic [3:0]    mem_rw;
  logic [31:0]   mem_data_out;
  logic          mem_ready;

  // slave: the LSU itself; master: the pipeline plus memory around it
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  mem_data_out, mem_ready,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_enable, mem_addr, mem_data_in, mem_rw
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output mem_data_out, mem_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_enable, mem_addr, mem_data_in, mem_rw
  );
endinterface

`default_nettype wire

// File: rtl/elbeth_lsu.sv
//----------------------------------------------------------------------------
// elbeth_lsu -- byte/half/word load-store initiator for one ELBETH memory port;
// optional BUSY timeout enabled by ELBETH_LSU_TIMEOUT_EN (rev 1.0)
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module elbeth_lsu #(
  parameter int AW      = 12,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  elbeth_lsu_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic          r_resp_valid, w_resp_valid;
  logic          r_resp_err,   w_resp_err;
  logic [31:0]   r_resp_rdata, w_resp_rdata;
  logic          r_mem_enable, w_mem_enable;
  logic [AW-1:0] r_mem_addr,   w_mem_addr;
  logic [31:0]   r_mem_data_in, w_mem_data_in;
  logic [3:0]    r_mem_rw,     w_mem_rw;
  logic          r_we,         w_we;
  logic [1:0]    r_size,       w_size;
  logic          r_signed,     w_signed;
  logic [1:0]    r_lane,       w_lane;

  logic          w_misaligned;
  logic [3:0]    w_strb;
  logic [31:0]   w_store_data;
  logic [31:0]   w_shifted;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic          w_timeout;

  assign w_misaligned = (bus.req_size == 2'b11)
                      | ((bus.req_size == 2'b01) & bus.req_addr[0])
                      | ((bus.req_size == 2'b10) & (|bus.req_addr[1:0]));

  always_comb begin
    w_strb       = 4'b1111;
    w_store_data = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        w_strb       = 4'b0001 << bus.req_addr[1:0];
        w_store_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_strb       = 4'b0011 << {bus.req_addr[1], 1'b0};
        w_store_data = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select uses the latched request, since req_* are only valid at accept
  assign w_shifted = bus.mem_data_out >> {r_lane, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = r_lane[1] ? bus.mem_data_out[31:16] : bus.mem_data_out[15:0];

  always_comb begin
    w_load = bus.mem_data_out;
    case (r_size)
      2'b00:   w_load = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      2'b01:   w_load = r_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
      default: ;
    endcase
  end

`ifdef ELBETH_LSU_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] r_tmo_cnt;

  // Fires on the edge the count would reach TIMEOUT; mem_ready takes priority in BUSY
  assign w_timeout = (state == BUSY) && !bus.mem_ready && (r_tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (state != BUSY) begin
      r_tmo_cnt <= '0;
    end else if (!bus.mem_ready) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    w_resp_valid  = 1'b0;
    w_resp_err    = r_resp_err;
    w_resp_rdata  = r_resp_rdata;
    w_mem_enable  = r_mem_enable;
    w_mem_addr    = r_mem_addr;
    w_mem_data_in = r_mem_data_in;
    w_mem_rw      = r_mem_rw;
    w_we          = r_we;
    w_size        = r_size;
    w_signed      = r_signed;
    w_lane        = r_lane;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (w_misaligned) begin
            state_next   = RESP;
            w_resp_valid = 1'b1;
            w_resp_err   = 1'b1;
            w_resp_rdata = 32'd0;
          end else begin
            state_next    = BUSY;
            w_mem_enable  = 1'b1;
            w_mem_addr    = bus.req_addr[AW+1:2];
            w_mem_data_in = w_store_data;
            w_mem_rw      = bus.req_we ? w_strb : 4'b0000;
            w_we          = bus.req_we;
            w_size        = bus.req_size;
            w_signed      = bus.req_signed;
            w_lane        = bus.req_addr[1:0];
          end
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          state_next   = RESP;
          w_resp_valid = 1'b1;
          w_resp_err   = 1'b0;
          w_resp_rdata = r_we ? 32'd0 : w_load;
          w_mem_enable = 1'b0;
          w_mem_rw     = 4'b0000;
        end else if (w_timeout) begin
          state_next   = RESP;
          w_resp_valid = 1'b1;
          w_resp_err   = 1'b1;
          w_resp_rdata = 32'd0;
          w_mem_enable = 1'b0;
          w_mem_rw     = 4'b0000;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= 32'd0;
      r_mem_enable  <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data_in <= 32'd0;
      r_mem_rw      <= 4'b0000;
      r_we          <= 1'b0;
      r_size        <= 2'b00;
      r_signed      <= 1'b0;
      r_lane        <= 2'b00;
    end else begin
      r_resp_valid  <= w_resp_valid;
      r_resp_err    <= w_resp_err;
      r_resp_rdata  <= w_resp_rdata;
      r_mem_enable  <= w_mem_enable;
      r_mem_addr    <= w_mem_addr;
      r_mem_data_in <= w_mem_data_in;
      r_mem_rw      <= w_mem_rw;
      r_we          <= w_we;
      r_size        <= w_size;
      r_signed      <= w_signed;
      r_lane        <= w_lane;
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_err    = r_resp_err;
  assign bus.resp_rdata  = r_resp_rdata;
  assign bus.mem_enable  = r_mem_enable;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_data_in = r_mem_data_in;
  assign bus.mem_rw      = r_mem_rw;

endmodule

`default_nettype wire
